// File: rtl/pe_row_drain.sv
// -----------------------------------------------------------------------------
// pe_row_drain
//
// Collects one row of systolic-array results and streams it out one word at a
// time. A PE column is captured on the rising edge of its finish level, sampled
// only in cycles where the array is enabled (i_valid). The captured columns go
// into a fill buffer (F). When every column has arrived, F is handed to a drain
// buffer (D), which is emitted column 0 first over a valid/ready handshake. F
// can refill while D drains. When the last word of D is accepted, a complete F
// is moved across on the same edge, so back-to-back rows leave no gap.
//
// Parameters
//   DIMENSION  number of PE columns in the row
//   C_BITS     width of one PE result
//
// Ports
//   i_clock     single clock, rising edge
//   i_reset     synchronous, active-high reset
//   i_valid     capture-side enable, the signal that also enables the PE array
//   i_c         PE results, column k at [k*C_BITS +: C_BITS]
//   i_finish    per-column PE finish levels
//   i_ready     downstream accepts the offered word
//   o_data      offered result word (0 when nothing is offered)
//   o_valid     o_data is valid
//   o_last      offered word is column DIMENSION-1 of its row
//   o_overflow  sticky: a finish event was dropped because both buffers were full
//   o_busy      a row is partially captured or being drained
//   o_col       (only with PE_ROW_DRAIN_TAG_EN) column index of the offered word
//
// Build option
//   PE_ROW_DRAIN_TAG_EN  when defined, adds the o_col column tag output.
// -----------------------------------------------------------------------------

module pe_row_drain #(
   parameter  int DIMENSION = 4,
   parameter  int C_BITS    = 16,
   localparam int IDX_W     = (DIMENSION > 1) ? $clog2(DIMENSION) : 1
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_valid,
   input  logic [DIMENSION*C_BITS-1:0] i_c,
   input  logic [DIMENSION-1:0]        i_finish,
   input  logic                        i_ready,
   output logic [C_BITS-1:0]           o_data,
   output logic                        o_valid,
   output logic                        o_last,
   output logic                        o_overflow,
   output logic                        o_busy
`ifdef PE_ROW_DRAIN_TAG_EN
   ,
   output logic [IDX_W-1:0]            o_col
`endif
);

   // IDLE: drain buffer empty. DRAIN: drain buffer full and being offered.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam logic [DIMENSION-1:0] ALL_COLS = '1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DIMENSION - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                state_q,  state_d;
   logic [DIMENSION-1:0]  finish_q, finish_d;   // last sampled finish levels
   logic [DIMENSION-1:0]  mask_q,   mask_d;     // F capture mask
   logic [IDX_W-1:0]      idx_q,    idx_d;      // D word being offered
   logic                  ovf_q,    ovf_d;

   logic [C_BITS-1:0]     fill_q  [DIMENSION];
   logic [C_BITS-1:0]     fill_d  [DIMENSION];
   logic [C_BITS-1:0]     drain_q [DIMENSION];
   logic [C_BITS-1:0]     drain_d [DIMENSION];

   // ---------------------------------------------------------------------------
   // Capture side
   // ---------------------------------------------------------------------------
   logic [DIMENSION-1:0]  rise;
   logic [DIMENSION-1:0]  mask_set;     // mask including this cycle's captures
   logic                  f_full_q;     // F was already complete entering the cycle
   logic                  f_complete;   // F complete once this cycle's captures land
   logic                  load_fill;    // move F into D on this edge

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves
      // a value unassigned and no latch is inferred.
      rise     = i_valid ? (i_finish & ~finish_q) : '0;
      finish_d = i_valid ? i_finish : finish_q;

      f_full_q = (mask_q == ALL_COLS);

      // A complete F is frozen until D takes it; rises in that window are lost.
      mask_set = f_full_q ? mask_q : (mask_q | rise);
      f_complete = (mask_set == ALL_COLS);

      for (int k = 0; k < DIMENSION; k++) begin
         fill_d[k] = fill_q[k];
         if (!f_full_q && rise[k]) begin
            // A repeat rise on an already captured column simply overwrites it.
            fill_d[k] = i_c[k*C_BITS +: C_BITS];
         end
      end

      // F complete on entry implies D is full (an empty D would have taken F
      // on the edge it completed), so any rise now is a dropped event.
      ovf_d = ovf_q | (f_full_q & (|rise));
   end

   // ---------------------------------------------------------------------------
   // Drain FSM: next state and buffer hand-off
   // ---------------------------------------------------------------------------
   logic xfer;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      load_fill = 1'b0;
      xfer      = (state_q == ST_DRAIN) && i_ready;

      unique case (state_q)
         ST_IDLE: begin
            if (f_complete) begin
               load_fill = 1'b1;
               idx_d     = '0;
               state_d   = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  // A waiting complete row follows with no idle cycle.
                  if (f_complete) begin
                     load_fill = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      mask_d = load_fill ? '0 : mask_set;

      for (int k = 0; k < DIMENSION; k++) begin
         drain_d[k] = load_fill ? fill_d[k] : drain_q[k];
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge value of every other register.
      if (i_reset) begin
         state_q  <= ST_IDLE;
         // All ones: a finish level still high when reset drops is not a rise.
         finish_q <= '1;
         mask_q   <= '0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         finish_q <= finish_d;
         mask_q   <= mask_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the row buffers carry no reset; their contents are only observed
   // through mask_q / state_q, which are reset, so stale data is never offered.
   always_ff @(posedge i_clock) begin
      fill_q  <= fill_d;
      drain_q <= drain_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_valid    = (state_q == ST_DRAIN);
   assign o_data     = o_valid ? drain_q[idx_q] : '0;
   assign o_last     = o_valid && (idx_q == LAST_IDX);
   assign o_overflow = ovf_q;
   assign o_busy     = (|mask_q) | o_valid;

`ifdef PE_ROW_DRAIN_TAG_EN
   assign o_col      = o_valid ? idx_q : '0;
`endif

endmodule

// File: tb/tb_pe_row_drain.sv
// -----------------------------------------------------------------------------
// tb_pe_row_drain
//
// Directed bench for pe_row_drain with DIMENSION=4, C_BITS=16. Inputs change
// 1 ns after a rising edge and outputs are compared there, so every value seen
// is the settled result of the preceding edge.
// -----------------------------------------------------------------------------

module tb_pe_row_drain;

   localparam int DIM = 4;
   localparam int CB  = 16;

   logic              i_clock;
   logic              i_reset;
   logic              i_valid;
   logic [DIM*CB-1:0] i_c;
   logic [DIM-1:0]    i_finish;
   logic              i_ready;
   logic [CB-1:0]     o_data;
   logic              o_valid;
   logic              o_last;
   logic              o_overflow;
   logic              o_busy;
`ifdef PE_ROW_DRAIN_TAG_EN
   logic [1:0]        o_col;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pe_row_drain #(
      .DIMENSION (DIM),
      .C_BITS    (CB)
   ) dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_valid    (i_valid),
      .i_c        (i_c),
      .i_finish   (i_finish),
      .i_ready    (i_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_last     (o_last),
      .o_overflow (o_overflow),
      .o_busy     (o_busy)
`ifdef PE_ROW_DRAIN_TAG_EN
      ,
      .o_col      (o_col)
`endif
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running required done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   function automatic logic [DIM*CB-1:0] pack(input logic [CB-1:0] c0, input logic [CB-1:0] c1,
                                               input logic [CB-1:0] c2, input logic [CB-1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   // Expects o_valid with the four given words in order, i_ready already 1.
   task automatic drain_row(input string tag, input logic [CB-1:0] e0, input logic [CB-1:0] e1,
                            input logic [CB-1:0] e2, input logic [CB-1:0] e3);
      logic [CB-1:0] e [DIM];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < DIM; i++) begin
         check($sformatf("%s valid w%0d", tag, i), 32'(o_valid), 32'd1);
         check($sformatf("%s data w%0d",  tag, i), 32'(o_data),  32'(e[i]));
         check($sformatf("%s last w%0d",  tag, i), 32'(o_last),  (i == DIM-1) ? 32'd1 : 32'd0);
         tick();
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid"}, 32'(o_valid), 32'd0);
      check({tag, " busy"},  32'(o_busy),  32'd0);
      check({tag, " data"},  32'(o_data),  32'd0);
      check({tag, " last"},  32'(o_last),  32'd0);
   endtask

   initial begin
      // ---------------- reset state ----------------
      i_reset  = 1'b1;
      i_valid  = 1'b1;
      i_finish = 4'b1111;
      i_c      = pack(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      i_ready  = 1'b1;
      tick();
      tick();
      check_idle("reset");
      check("reset ovf", 32'(o_overflow), 32'd0);

      i_reset  = 1'b0;
      i_finish = 4'b0000;
      tick();
      check_idle("post reset");

      // ---------------- successive column rises ----------------
      i_finish = 4'b0001; i_c = pack(16'h0010, 16'hEE00, 16'hEE00, 16'hEE00); tick();
      check("seq busy c0", 32'(o_busy), 32'd1);
      check("seq valid c0", 32'(o_valid), 32'd0);
      i_finish = 4'b0011; i_c = pack(16'hEE01, 16'h0020, 16'hEE01, 16'hEE01); tick();
      check("seq valid c1", 32'(o_valid), 32'd0);
      i_finish = 4'b0111; i_c = pack(16'hEE02, 16'hEE02, 16'h0030, 16'hEE02); tick();
      check("seq valid c2", 32'(o_valid), 32'd0);
      i_finish = 4'b1111; i_c = pack(16'hEE03, 16'hEE03, 16'hEE03, 16'h0040); tick();
      drain_row("seq", 16'h0010, 16'h0020, 16'h0030, 16'h0040);
      check_idle("seq end");
      i_finish = 4'b0000; tick();

      // ---------------- all columns in one cycle ----------------
      i_finish = 4'b1111; i_c = pack(16'h0111, 16'h0222, 16'h0333, 16'h0444); tick();
      i_finish = 4'b0000;
      drain_row("all", 16'h0111, 16'h0222, 16'h0333, 16'h0444);
      check_idle("all end");
      check("all ovf", 32'(o_overflow), 32'd0);

      // ---------------- repeat rise overwrites a slot ----------------
      i_finish = 4'b0001; i_c = pack(16'h0AAA, 16'h0E01, 16'h0E02, 16'h0E03); tick();
      i_finish = 4'b0000; tick();
      i_finish = 4'b0001; i_c = pack(16'h0BBB, 16'h0E11, 16'h0E12, 16'h0E13); tick();
      check("ovw valid", 32'(o_valid), 32'd0);
      i_finish = 4'b0000; tick();
      i_finish = 4'b1110; i_c = pack(16'hFFFF, 16'h0B1, 16'h0B2, 16'h0B3); tick();
      i_finish = 4'b0000;
      drain_row("ovw", 16'h0BBB, 16'h00B1, 16'h00B2, 16'h00B3);
      check("ovw ovf", 32'(o_overflow), 32'd0);

      // ---------------- stall, two rows, overflow ----------------
      i_ready  = 1'b0;
      i_finish = 4'b1111; i_c = pack(16'hA000, 16'hA001, 16'hA002, 16'hA003); tick();
      check("stall row1 valid", 32'(o_valid), 32'd1);
      i_finish = 4'b0000; tick();
      i_finish = 4'b1111; i_c = pack(16'hB000, 16'hB001, 16'hB002, 16'hB003); tick();
      check("stall row2 ovf", 32'(o_overflow), 32'd0);
      i_finish = 4'b0000; tick();
      i_finish = 4'b0001; i_c = pack(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD); tick();
      check("stall ovf", 32'(o_overflow), 32'd1);
      check("stall hold valid", 32'(o_valid), 32'd1);
      check("stall hold data", 32'(o_data), 32'hA000);
      check("stall busy", 32'(o_busy), 32'd1);
      i_finish = 4'b0000;
      i_ready  = 1'b1;
      drain_row("stall r1", 16'hA000, 16'hA001, 16'hA002, 16'hA003);
      drain_row("stall r2", 16'hB000, 16'hB001, 16'hB002, 16'hB003);
      check_idle("stall end");
      check("stall ovf sticky", 32'(o_overflow), 32'd1);
      i_reset = 1'b1; tick();
      check("ovf cleared", 32'(o_overflow), 32'd0);
      i_reset = 1'b0; tick();

      // ---------------- back-to-back rows ----------------
      i_finish = 4'b1111; i_c = pack(16'hC000, 16'hC001, 16'hC002, 16'hC003); tick();
      i_finish = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b r1 data w%0d", i), 32'(o_data), 32'(16'hC000 + 16'(i)));
         tick();
      end
      check("b2b r1 data w3", 32'(o_data), 32'hC003);
      check("b2b r1 last", 32'(o_last), 32'd1);
      i_finish = 4'b1111; i_c = pack(16'hD000, 16'hD001, 16'hD002, 16'hD003); tick();
      i_finish = 4'b0000;
      drain_row("b2b r2", 16'hD000, 16'hD001, 16'hD002, 16'hD003);
      check_idle("b2b end");

      // ---------------- finish held through reset ----------------
      i_finish = 4'b1111;
      i_reset  = 1'b1; tick();
      i_reset  = 1'b0; tick();
      tick();
      check_idle("held rst");
      i_finish = 4'b0000; tick();

      // ---------------- reset during drain ----------------
      i_finish = 4'b1111; i_c = pack(16'h5000, 16'h5001, 16'h5002, 16'h5003); tick();
      check("rstdrain valid", 32'(o_valid), 32'd1);
      tick();
      i_reset = 1'b1; tick();
      check_idle("rstdrain");
      i_reset = 1'b0; tick();
      check_idle("rstdrain after");
      i_finish = 4'b0000; tick();

      // ---------------- i_valid low ----------------
      i_valid  = 1'b0;
      i_finish = 4'b1111; i_c = pack(16'h6000, 16'h6001, 16'h6002, 16'h6003); tick();
      i_finish = 4'b0000; tick();
      i_finish = 4'b1111; tick();
      check_idle("novalid");
      i_valid  = 1'b1;
      i_c = pack(16'h7000, 16'h7001, 16'h7002, 16'h7003); tick();
      i_valid  = 1'b0;
      i_finish = 4'b0000;
      drain_row("novalid drain", 16'h7000, 16'h7001, 16'h7002, 16'h7003);
      check_idle("novalid end");
      check("final ovf", 32'(o_overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
